cnn_multich_conv_pool_engine: RTL and testbench

//  Parametrised successor to the single-kernel CNN processor: valid (no-pad) KxK convolution of one

---
 rtl/cnn_multich_conv_pool_engine_pkg.sv | 49 ++++
 rtl/cnn_multich_conv_pool_engine_mac.sv | 57 +++++
 rtl/cnn_multich_conv_pool_engine.sv | 219 +++++++++++++++++++++
 tb/tb_cnn_multich_conv_pool_engine.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_multich_conv_pool_engine_pkg.sv
// Shared widths, derived geometry, address-map constants and FSM states
// for the multi-channel convolution/pooling engine.
package cnn_multich_conv_pool_engine_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int WEIGHT_WIDTH = 8;
  localparam int BIAS_WIDTH   = 16;
  localparam int ACC_WIDTH    = 24;
  localparam int IMG_W        = 8;
  localparam int IMG_H        = 8;
  localparam int K            = 3;
  localparam int POOL         = 2;
  localparam int NUM_CH       = 2;

  localparam int CONV_W      = IMG_W - K + 1;
  localparam int CONV_H      = IMG_H - K + 1;
  localparam int PW          = CONV_W / POOL;
  localparam int PH          = CONV_H / POOL;
  localparam int TAPS        = K * K;
  localparam int KERN_STRIDE = K * K + 1;
  localparam int IMG_DEPTH   = IMG_W * IMG_H;
  localparam int KERN_DEPTH  = NUM_CH * KERN_STRIDE;
  localparam int OUT_DEPTH   = NUM_CH * PH * PW;
  localparam int POOL_AREA   = POOL * POOL;
  localparam int POOL_SHIFT  = $clog2(POOL_AREA);
  localparam int SUM_W       = DATA_WIDTH + POOL_SHIFT;

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int WR_AW   = addr_bits((IMG_DEPTH > KERN_DEPTH) ? IMG_DEPTH : KERN_DEPTH);
  localparam int IMG_AW  = addr_bits(IMG_DEPTH);
  localparam int KERN_AW = addr_bits(KERN_DEPTH);
  localparam int OUT_AW  = addr_bits(OUT_DEPTH);
  localparam int CH_W    = addr_bits(NUM_CH);
  localparam int PR_W    = addr_bits(PH);
  localparam int PC_W    = addr_bits(PW);
  localparam int WIN_W   = addr_bits(POOL);
  localparam int TAP_W   = addr_bits(K);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ACT,
    ST_WR
  } state_e;

endpackage

// File: rtl/cnn_multich_conv_pool_engine_mac.sv
// Single-MAC accumulator with bias preload on the first tap, followed by
// combinational ReLU and saturation to the signed output width.
module cnn_mac_act_unit
  import cnn_multich_conv_pool_engine_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mac_en,
  input  logic                           first_tap,
  input  logic        [DATA_WIDTH-1:0]   pixel,
  input  logic signed [WEIGHT_WIDTH-1:0] weight,
  input  logic signed [BIAS_WIDTH-1:0]   bias,
  input  logic                           relu_en,
  output logic signed [DATA_WIDTH-1:0]   act_val
);

  localparam int PROD_W = DATA_WIDTH + 1 + WEIGHT_WIDTH;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_base, act_pre;
  logic signed [DATA_WIDTH:0]  pix_s;
  logic signed [PROD_W-1:0]    prod;

  // Pixels are unsigned, so widen with a zero sign bit before the signed multiply.
  always_comb begin
    pix_s    = {1'b0, pixel};
    prod     = pix_s * weight;
    acc_base = first_tap ? {{(ACC_WIDTH-BIAS_WIDTH){bias[BIAS_WIDTH-1]}}, bias} : acc_q;
    acc_d    = acc_q;
    if (mac_en) begin
      acc_d = acc_base + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // The value fits when every bit from the output sign bit upward agrees.
  always_comb begin
    act_pre = acc_q;
    if (relu_en && acc_q[ACC_WIDTH-1]) begin
      act_pre = '0;
    end
    if ((&act_pre[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|act_pre[ACC_WIDTH-1:DATA_WIDTH-1])) begin
      act_val = act_pre[DATA_WIDTH-1:0];
    end else if (act_pre[ACC_WIDTH-1]) begin
      act_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      act_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cnn_multich_conv_pool_engine.sv
// Multi-channel valid KxK convolution with per-run ReLU and max/avg pooling;
// host-loaded image/kernel RAMs, sequential single-MAC datapath, pooled output RAM.
module cnn_multich_conv_pool_engine
  import cnn_multich_conv_pool_engine_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic                  pool_avg,
  input  logic                  wr_en,
  input  logic                  mem_select,
  input  logic [WR_AW-1:0]      wr_addr,
  input  logic [BIAS_WIDTH-1:0] data_in,
  input  logic [OUT_AW-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done
);

  state_e state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [PR_W-1:0]  pr_q, pr_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [WIN_W-1:0] wy_q, wy_d, wx_q, wx_d;
  logic [TAP_W-1:0] ky_q, ky_d, kx_q, kx_d;
  logic             relu_q, relu_d, avg_q, avg_d, done_q, done_d;
  logic signed [DATA_WIDTH-1:0] pool_max_q, pool_max_d;
  logic signed [SUM_W-1:0]      pool_sum_q, pool_sum_d;

  logic [DATA_WIDTH-1:0] img_ram  [IMG_DEPTH];
  logic [BIAS_WIDTH-1:0] kern_ram [KERN_DEPTH];
  logic [DATA_WIDTH-1:0] out_ram  [OUT_DEPTH];

  int row, col, kbase;
  logic [IMG_AW-1:0]  img_addr;
  logic [KERN_AW-1:0] tap_addr, bias_addr;
  logic [OUT_AW-1:0]  out_addr;
  logic [DATA_WIDTH-1:0]          pixel;
  logic signed [WEIGHT_WIDTH-1:0] weight;
  logic signed [BIAS_WIDTH-1:0]   bias;
  logic mac_en, first_tap, first_win, out_we, host_wr;
  logic signed [DATA_WIDTH-1:0] act_val, out_wdata;

  always_comb begin
    row       = int'(pr_q) * POOL + int'(wy_q) + int'(ky_q);
    col       = int'(pc_q) * POOL + int'(wx_q) + int'(kx_q);
    kbase     = int'(ch_q) * KERN_STRIDE;
    img_addr  = IMG_AW'(row * IMG_W + col);
    tap_addr  = KERN_AW'(kbase + int'(ky_q) * K + int'(kx_q));
    bias_addr = KERN_AW'(kbase + TAPS);
    out_addr  = OUT_AW'(int'(ch_q) * PH * PW + int'(pr_q) * PW + int'(pc_q));
    pixel     = img_ram[img_addr];
    weight    = kern_ram[tap_addr][WEIGHT_WIDTH-1:0];
    bias      = kern_ram[bias_addr];
  end

  cnn_mac_act_unit u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .mac_en    (mac_en),
    .first_tap (first_tap),
    .pixel     (pixel),
    .weight    (weight),
    .bias      (bias),
    .relu_en   (relu_q),
    .act_val   (act_val)
  );

  // Host writes land only while idle; a start in the same cycle still sees IDLE.
  assign host_wr   = wr_en && (state_q == ST_IDLE);
  assign out_wdata = avg_q ? DATA_WIDTH'(pool_sum_q >>> POOL_SHIFT) : pool_max_q;

  always_ff @(posedge clk) begin
    if (host_wr && !mem_select && (int'(wr_addr) < IMG_DEPTH)) begin
      img_ram[wr_addr[IMG_AW-1:0]] <= data_in[DATA_WIDTH-1:0];
    end
    if (host_wr && mem_select && (int'(wr_addr) < KERN_DEPTH)) begin
      kern_ram[wr_addr[KERN_AW-1:0]] <= data_in;
    end
    if (out_we) begin
      out_ram[out_addr] <= out_wdata;
    end
  end

  always_comb begin
    data_out = '0;
    if (int'(rd_addr) < OUT_DEPTH) begin
      data_out = out_ram[rd_addr];
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    pr_d       = pr_q;
    pc_d       = pc_q;
    wy_d       = wy_q;
    wx_d       = wx_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    relu_d     = relu_q;
    avg_d      = avg_q;
    done_d     = done_q;
    pool_max_d = pool_max_q;
    pool_sum_d = pool_sum_q;
    mac_en     = 1'b0;
    out_we     = 1'b0;
    first_tap  = (ky_q == '0) && (kx_q == '0);
    first_win  = (wy_q == '0) && (wx_q == '0);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_MAC;
          done_d  = 1'b0;
          relu_d  = relu_en;
          avg_d   = pool_avg;
          ch_d    = '0;
          pr_d    = '0;
          pc_d    = '0;
          wy_d    = '0;
          wx_d    = '0;
          ky_d    = '0;
          kx_d    = '0;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (kx_q == TAP_W'(K-1)) begin
          kx_d = '0;
          if (ky_q == TAP_W'(K-1)) begin
            ky_d    = '0;
            state_d = ST_ACT;
          end else begin
            ky_d = ky_q + TAP_W'(1);
          end
        end else begin
          kx_d = kx_q + TAP_W'(1);
        end
      end
      ST_ACT: begin
        // Both pooling flavours are tracked; the mode only picks which one is written.
        pool_max_d = (first_win || (act_val > pool_max_q)) ? act_val : pool_max_q;
        pool_sum_d = (first_win ? SUM_W'(0) : pool_sum_q)
                   + {{POOL_SHIFT{act_val[DATA_WIDTH-1]}}, act_val};
        state_d    = ST_MAC;
        if (wx_q == WIN_W'(POOL-1)) begin
          wx_d = '0;
          if (wy_q == WIN_W'(POOL-1)) begin
            wy_d    = '0;
            state_d = ST_WR;
          end else begin
            wy_d = wy_q + WIN_W'(1);
          end
        end else begin
          wx_d = wx_q + WIN_W'(1);
        end
      end
      ST_WR: begin
        out_we  = 1'b1;
        state_d = ST_MAC;
        if (pc_q == PC_W'(PW-1)) begin
          pc_d = '0;
          if (pr_q == PR_W'(PH-1)) begin
            pr_d = '0;
            if (ch_q == CH_W'(NUM_CH-1)) begin
              ch_d    = '0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            pr_d = pr_q + PR_W'(1);
          end
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      pr_q       <= '0;
      pc_q       <= '0;
      wy_q       <= '0;
      wx_q       <= '0;
      ky_q       <= '0;
      kx_q       <= '0;
      relu_q     <= 1'b0;
      avg_q      <= 1'b0;
      done_q     <= 1'b0;
      pool_max_q <= '0;
      pool_sum_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      pr_q       <= pr_d;
      pc_q       <= pc_d;
      wy_q       <= wy_d;
      wx_q       <= wx_d;
      ky_q       <= ky_d;
      kx_q       <= kx_d;
      relu_q     <= relu_d;
      avg_q      <= avg_d;
      done_q     <= done_d;
      pool_max_q <= pool_max_d;
      pool_sum_q <= pool_sum_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_cnn_multich_conv_pool_engine.sv
// Directed bench for the conv/pool engine on image p(r,c)=(r*8+c)%32; expected
// pooled outputs are hand-derived tables fed to a read scoreboard.
module tb_cnn_multich_conv_pool_engine;
  import cnn_multich_conv_pool_engine_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  relu_en = 1'b0;
  logic                  pool_avg = 1'b0;
  logic                  wr_en = 1'b0;
  logic                  mem_select = 1'b0;
  logic [WR_AW-1:0]      wr_addr = '0;
  logic [BIAS_WIDTH-1:0] data_in = '0;
  logic [OUT_AW-1:0]     rd_addr = '0;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  busy, done;

  int    checks = 0;
  int    failures = 0;
  int    exp_val_q[$];
  string exp_name_q[$];
  logic  rd_req = 1'b0;
  int    mon_act, mon_exp;
  string mon_name;
  int    cyc;
  bit    fin;

  // ch0 identity kernel with bias -5, ch1 all -1 with bias 0
  int ch0_max_relu[9]  = '{13, 15, 17, 21, 23, 25, 13, 15, 17};
  int ch0_avg_relu[9]  = '{8, 10, 12, 10, 11, 12, 8, 10, 12};
  int ch1_max_plain[9] = '{-81, -99, -117, -105, -123, -128, -81, -99, -117};
  int all_zero[9]      = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
  int all_sat[9]       = '{127, 127, 127, 127, 127, 127, 127, 127, 127};

  always #5 clk = ~clk;

  cnn_multich_conv_pool_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .relu_en    (relu_en),
    .pool_avg   (pool_avg),
    .wr_en      (wr_en),
    .mem_select (mem_select),
    .wr_addr    (wr_addr),
    .data_in    (data_in),
    .rd_addr    (rd_addr),
    .data_out   (data_out),
    .busy       (busy),
    .done       (done)
  );

  // Read monitor: one scoreboard entry per cycle in which a read is presented
  always @(negedge clk) begin
    if (rd_req) begin
      checks++;
      if (exp_val_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL scoreboard_underflow data_out=%0d with no expected entry",
                 $signed(data_out));
      end else begin
        mon_exp  = exp_val_q.pop_front();
        mon_name = exp_name_q.pop_front();
        mon_act  = int'($signed(data_out));
        if (mon_act != mon_exp) begin
          failures++;
          $display("[TB] FAIL %s actual=%0d expected=%0d", mon_name, mon_act, mon_exp);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic writeMem(input bit sel, input int addr, input int data);
    wr_en      = 1'b1;
    mem_select = sel;
    wr_addr    = WR_AW'(addr);
    data_in    = BIAS_WIDTH'(data);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic loadImage();
    for (int a = 0; a < IMG_DEPTH; a++) writeMem(1'b0, a, a % 32);
  endtask

  task automatic loadKernel(input int ch, input int center_w, input int other_w, input int b);
    for (int t = 0; t < TAPS; t++)
      writeMem(1'b1, ch * KERN_STRIDE + t, (t == (K / 2) * K + K / 2) ? center_w : other_w);
    writeMem(1'b1, ch * KERN_STRIDE + TAPS, b);
  endtask

  task automatic readExpect(input int addr, input int expected, input string name);
    rd_addr = OUT_AW'(addr);
    exp_val_q.push_back(expected);
    exp_name_q.push_back(name);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic readTable(input int base, input int vals[9], input string tag);
    for (int i = 0; i < 9; i++) readExpect(base + i, vals[i], $sformatf("%s_out%0d", tag, base + i));
  endtask

  // Starts a run, flips the mode inputs after acceptance, optionally pokes
  // start/wr_en mid-run or aborts via reset, and counts cycles to done.
  task automatic applyStimulus(input bit relu, input bit avg, input int disturb_at,
                               input int abort_at, output int cycles, output bit finished);
    relu_en  = relu;
    pool_avg = avg;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    relu_en  = ~relu;
    pool_avg = ~avg;
    checkOutput("done_cleared_on_start", int'(done), 0);
    checkOutput("busy_after_start", int'(busy), 1);
    cycles   = 0;
    finished = 1'b0;
    while (cycles < 2000) begin
      @(posedge clk);
      cycles++;
      #1;
      start = 1'b0;
      wr_en = 1'b0;
      if (cycles == disturb_at) begin
        start      = 1'b1;
        wr_en      = 1'b1;
        mem_select = 1'b1;
        wr_addr    = WR_AW'(4);
        data_in    = '0;
      end
      if (cycles == abort_at) begin
        rst_n = 1'b0;
        return;
      end
      if (done) begin
        finished = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    loadImage();
    loadKernel(0, 1, 0, -5);
    loadKernel(1, -1, -1, 0);

    $display("[TB] case 1: relu on, max pool");
    applyStimulus(1'b1, 1'b0, -1, -1, cyc, fin);
    checkOutput("t1_finished", int'(fin), 1);
    checkOutput("t1_latency", cyc, 738);
    checkOutput("t1_busy_end", int'(busy), 0);
    readTable(0, ch0_max_relu, "t1");
    readTable(9, all_zero, "t1");
    checkOutput("t1_done_level", int'(done), 1);

    $display("[TB] case 2: relu on, avg pool");
    applyStimulus(1'b1, 1'b1, -1, -1, cyc, fin);
    checkOutput("t2_latency", cyc, 738);
    readTable(0, ch0_avg_relu, "t2");
    readExpect(9, 0, "t2_out9");

    $display("[TB] case 3: relu off, max then avg");
    applyStimulus(1'b0, 1'b0, -1, -1, cyc, fin);
    checkOutput("t3_latency", cyc, 738);
    readTable(9, ch1_max_plain, "t3");
    readExpect(0, 13, "t3_out0");
    readExpect(3, 21, "t3_out3");
    applyStimulus(1'b0, 1'b1, -1, -1, cyc, fin);
    checkOutput("t3b_latency", cyc, 738);
    readExpect(9, -107, "t3b_out9");
    readExpect(10, -116, "t3b_out10");
    readExpect(11, -125, "t3b_out11");
    readExpect(12, -119, "t3b_out12");
    readExpect(3, 8, "t3b_out3");

    $display("[TB] case 4: positive saturation");
    loadKernel(0, 127, 0, 0);
    applyStimulus(1'b0, 1'b0, -1, -1, cyc, fin);
    checkOutput("t4_latency", cyc, 738);
    readTable(0, all_sat, "t4");
    readExpect(9, -81, "t4_out9");

    $display("[TB] case 5: reset mid-run");
    loadKernel(0, 1, 0, -5);
    applyStimulus(1'b1, 1'b0, -1, 300, cyc, fin);
    checkOutput("t5_aborted", int'(fin), 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_reset_done", int'(done), 0);
    checkOutput("t5_reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    readExpect(0, 13, "t5_partial_out0");
    readExpect(6, 13, "t5_partial_out6");
    readExpect(7, 127, "t5_retained_out7");
    applyStimulus(1'b1, 1'b0, -1, -1, cyc, fin);
    checkOutput("t5_rerun_latency", cyc, 738);
    readTable(0, ch0_max_relu, "t5");

    $display("[TB] case 6: start and write while busy");
    applyStimulus(1'b1, 1'b0, 100, -1, cyc, fin);
    checkOutput("t6_latency", cyc, 738);
    readTable(0, ch0_max_relu, "t6");
    checkOutput("t6_done_level", int'(done), 1);
    applyStimulus(1'b1, 1'b1, -1, -1, cyc, fin);
    checkOutput("t7_latency", cyc, 738);
    readExpect(0, 8, "t7_out0");
    readExpect(4, 11, "t7_out4");

    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", exp_val_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
